ahb_arbiter_slave_3: RTL

Round-robin address-phase arbiter for AHB slave port 3; sits directly upstream of the slave-3 one-hot payload mux. Collects per-master requests already decoded to slave 3, picks one owner, and drives the one-hot `sel` vector that steers master payloads onto the slave. Also produces a data-phase select that lags one accepted transfer behind, for the response return path. Provides burst/lock hold, a starvation limit, and an idle state with no master selected.

---
 rtl/ahb_arbiter_slave_3.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ahb_arbiter_slave_3.sv
// Round-robin address-phase arbiter for AHB slave port 3: one-hot owner select,
// data-phase select lagging by one accepted transfer, burst/lock hold and a beat limit.
module ahb_arbiter_slave_3 #(
    parameter int CHANNEL_NUM = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [CHANNEL_NUM-1:0]         req,
    input  logic [CHANNEL_NUM-1:0]         lock,
    input  logic [CHANNEL_NUM-1:0]         last,
    input  logic                           hready,
    output logic [CHANNEL_NUM-1:0]         sel,
    output logic [CHANNEL_NUM-1:0]         sel_data,
    output logic [$clog2(CHANNEL_NUM)-1:0] grant_id
);

    localparam int IDW = $clog2(CHANNEL_NUM);
    localparam int CW  = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDW-1:0]         owner_r;
    logic [IDW-1:0]         owner_nxt_s;
    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         ptr_nxt_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic [CHANNEL_NUM-1:0] sel_r;
    logic [CHANNEL_NUM-1:0] sel_nxt_s;
    logic [CHANNEL_NUM-1:0] sel_data_r;
    logic [CHANNEL_NUM-1:0] sel_data_nxt_s;

    logic [IDW-1:0]         scan_s;
    logic [IDW-1:0]         win_s;
    logic                   found_s;
    logic                   release_s;
    logic                   own_req_s;
    logic                   own_lock_s;
    logic                   own_last_s;
    logic                   at_max_s;

    assign own_req_s  = req[owner_r];
    assign own_lock_s = lock[owner_r];
    assign own_last_s = last[owner_r];
    assign at_max_s   = (cnt_r == CW'(MAX_HOLD - 1));

    // Round-robin winner: first requester at or after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        scan_s  = {IDW{1'b0}};
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            scan_s  = IDW'((int'(ptr_r) + k) % CHANNEL_NUM);
            win_s   = (!found_s && req[scan_s]) ? scan_s : win_s;
            found_s = found_s | req[scan_s];
        end
    end

    // Next-state: release decision, regrant, pointer advance and beat counter.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        release_s   = 1'b0;
        case (state_r)
            IDLE:    release_s = |req;
            // a locked owner ignores both last and the beat limit
            OWNED:   release_s = !own_req_s || (own_last_s && !own_lock_s) || (at_max_s && !own_lock_s);
            default: release_s = 1'b1;
        endcase
        if (hready && release_s) begin
            cnt_nxt_s = {CW{1'b0}};
            if (found_s) begin
                state_nxt_s = OWNED;
                owner_nxt_s = win_s;
                ptr_nxt_s   = (win_s == IDW'(CHANNEL_NUM - 1)) ? {IDW{1'b0}} : (win_s + IDW'(1'b1));
            end else begin
                state_nxt_s = IDLE;
                owner_nxt_s = {IDW{1'b0}};
            end
        end else if (hready && (state_r == OWNED) && own_req_s && !at_max_s) begin
            cnt_nxt_s = cnt_r + CW'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output next values: one-hot owner select and data-phase select.
    always_comb begin
        sel_nxt_s      = {CHANNEL_NUM{1'b0}};
        sel_data_nxt_s = hready ? sel_r : sel_data_r;
        if (state_nxt_s == OWNED) begin
            sel_nxt_s = CHANNEL_NUM'(1'b1) << owner_nxt_s;
        end else begin
            sel_nxt_s = {CHANNEL_NUM{1'b0}};
        end
    end

    // State and registered outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r    <= IDLE;
            owner_r    <= {IDW{1'b0}};
            ptr_r      <= {IDW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            sel_r      <= {CHANNEL_NUM{1'b0}};
            sel_data_r <= {CHANNEL_NUM{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            ptr_r      <= ptr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            sel_r      <= sel_nxt_s;
            sel_data_r <= sel_data_nxt_s;
        end
    end

    assign sel      = sel_r;
    assign sel_data = sel_data_r;
    assign grant_id = owner_r;

endmodule
